// File: rtl/top_puf.sv
// Arbiter-PUF emulator: additive-delay model over an 8-bit challenge, with stage
// weights drawn from a Galois LFSR seeded per device. One stage per enabled clock.
module top_puf #(
    parameter logic [15:0] DEVICE_SEED = 16'hACE1,
    parameter int unsigned ACC_W       = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] chall_in,
    output logic [7:0] response,
    output logic       ready
);

    localparam logic [15:0] SEED = (DEVICE_SEED == 16'h0000) ? 16'hACE1 : DEVICE_SEED;
    localparam logic [15:0] TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t                   state;
    logic [7:0]               chal_q;
    logic [15:0]              lfsr;
    logic [2:0]               idx_i;
    logic [2:0]               idx_j;
    logic signed [ACC_W-1:0]  acc;

    logic [15:0]              rot_wide;
    logic [7:0]               c_mix;
    logic                     parity;
    logic signed [ACC_W-1:0]  w_ext;
    logic signed [ACC_W-1:0]  acc_next;
    logic [15:0]              lfsr_next;

    // Upper byte of the doubled challenge shifted left is the rotate-left by idx_i.
    always_comb begin
        rot_wide  = {chal_q, chal_q} << idx_i;
        c_mix     = rot_wide[15:8];
        parity    = ^(c_mix >> idx_j);
        w_ext     = {{(ACC_W-8){lfsr[7]}}, lfsr[7:0]};
        acc_next  = parity ? (acc - w_ext) : (acc + w_ext);
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            response <= '0;
            ready    <= 1'b0;
            acc      <= '0;
            idx_i    <= '0;
            idx_j    <= '0;
            chal_q   <= '0;
            lfsr     <= SEED;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        chal_q   <= chall_in;
                        lfsr     <= SEED;
                        idx_i    <= '0;
                        idx_j    <= '0;
                        acc      <= '0;
                        response <= '0;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    if (en) begin
                        lfsr  <= lfsr_next;
                        idx_j <= idx_j + 3'd1;
                        if (idx_j == 3'd7) begin
                            response[idx_i] <= ~acc_next[ACC_W-1];
                            acc             <= '0;
                            idx_i           <= idx_i + 3'd1;
                            if (idx_i == 3'd7) begin
                                state <= DONE;
                                ready <= 1'b1;
                            end
                        end else begin
                            acc <= acc_next;
                        end
                    end
                end
                DONE: begin
                    // A new challenge restarts from scratch so the result matches a fresh run.
                    if (en && (chall_in != chal_q)) begin
                        chal_q   <= chall_in;
                        lfsr     <= SEED;
                        idx_i    <= '0;
                        idx_j    <= '0;
                        acc      <= '0;
                        response <= '0;
                        ready    <= 1'b0;
                        state    <= EVAL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top_puf.sv
// Bench for top_puf: four device instances share stimulus; responses are checked
// against an integer reference model of the additive-delay PUF.
module tb_top_puf;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] chall_in;
    logic [7:0] resp_d, resp_a, resp_b, resp_z;
    logic       rdy_d, rdy_a, rdy_b, rdy_z;

    int n_cmp = 0;
    int n_err = 0;

    top_puf #(.DEVICE_SEED(16'hACE1), .ACC_W(12)) u_dut (
        .clk(clk), .rst(rst), .en(en), .chall_in(chall_in), .response(resp_d), .ready(rdy_d));
    top_puf #(.DEVICE_SEED(16'h1234), .ACC_W(12)) u_dev_a (
        .clk(clk), .rst(rst), .en(en), .chall_in(chall_in), .response(resp_a), .ready(rdy_a));
    top_puf #(.DEVICE_SEED(16'hBEEF), .ACC_W(12)) u_dev_b (
        .clk(clk), .rst(rst), .en(en), .chall_in(chall_in), .response(resp_b), .ready(rdy_b));
    top_puf #(.DEVICE_SEED(16'h0000), .ACC_W(12)) u_dev_z (
        .clk(clk), .rst(rst), .en(en), .chall_in(chall_in), .response(resp_z), .ready(rdy_z));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [15:0] seed, input logic [7:0] ch);
        logic [15:0] s;
        logic [7:0]  r;
        logic [7:0]  c;
        logic        p;
        int          acc;
        int          w;
        s = (seed == 16'h0000) ? 16'hACE1 : seed;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) c[k] = ch[(k - i + 8) % 8];
            acc = 0;
            for (int j = 0; j < 8; j++) begin
                p = 1'b0;
                for (int k = j; k < 8; k++) p = p ^ c[k];
                w = int'(s[7:0]);
                if (w > 127) w = w - 256;
                acc = p ? (acc - w) : (acc + w);
                s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
            end
            r[i] = (acc >= 0);
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_run(input logic [7:0] ch);
        rst      = 1'b1;
        en       = 1'b1;
        chall_in = ch;
        @(posedge clk); #1;
        check("reset_response", int'(resp_d), 0);
        check("reset_ready", int'(rdy_d), 0);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int lat);
        int n;
        lat = -1;
        n   = 0;
        while (lat < 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (rdy_d) lat = n;
        end
    endtask

    typedef struct {
        logic [7:0] ch;
        logic [7:0] exp_resp;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];
    bit   seen[256];

    initial begin
        int lat;
        int lat2;
        int distinct;
        int hd_sum;
        logic [7:0] tab_ch[6];

        rst = 1'b1; en = 1'b0; chall_in = 8'h00;
        tab_ch[0] = 8'h01; tab_ch[1] = 8'h5A; tab_ch[2] = 8'hC3;
        tab_ch[3] = 8'hFF; tab_ch[4] = 8'h80; tab_ch[5] = 8'h7E;
        for (int k = 0; k < 6; k++) begin
            vecs[k].ch       = tab_ch[k];
            vecs[k].exp_resp = model(16'hACE1, tab_ch[k]);
            vecs[k].exp_lat  = 65;
        end
        repeat (2) @(posedge clk);
        #1;

        // Directed table: latency and response per challenge.
        for (int k = 0; k < 6; k++) begin
            start_run(vecs[k].ch);
            wait_ready(100, lat);
            check($sformatf("tab_lat_%02h", vecs[k].ch), lat, vecs[k].exp_lat);
            check($sformatf("tab_resp_%02h", vecs[k].ch), int'(resp_d), int'(vecs[k].exp_resp));
        end

        // Full sweep across all four devices.
        distinct = 0;
        hd_sum   = 0;
        for (int c = 1; c < 256; c++) begin
            start_run(8'(c));
            wait_ready(100, lat);
            check("sweep_lat", lat, 65);
            check($sformatf("sweep_ace1_%02h", c), int'(resp_d), int'(model(16'hACE1, 8'(c))));
            check($sformatf("sweep_1234_%02h", c), int'(resp_a), int'(model(16'h1234, 8'(c))));
            check($sformatf("sweep_beef_%02h", c), int'(resp_b), int'(model(16'hBEEF, 8'(c))));
            check($sformatf("sweep_seed0_%02h", c), int'(resp_z), int'(model(16'hACE1, 8'(c))));
            if (!seen[resp_d]) begin
                seen[resp_d] = 1'b1;
                distinct++;
            end
            hd_sum += $countones(resp_a ^ resp_b);
        end
        check("distinct_ge_30", int'(distinct >= 30), 1);
        check("hd_avg_3_to_5", int'(hd_sum >= 3 * 255 && hd_sum <= 5 * 255), 1);

        // Repeat of an earlier challenge after unrelated history.
        start_run(8'h5A);
        wait_ready(100, lat);
        check("repeat_5a_resp", int'(resp_d), int'(model(16'hACE1, 8'h5A)));

        // Ten-cycle enable pause mid-evaluation.
        start_run(8'hC3);
        repeat (20) begin @(posedge clk); #1; end
        en = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("pause_ready_low", int'(rdy_d), 0);
        en = 1'b1;
        wait_ready(100, lat2);
        check("pause_lat", (lat2 < 0) ? -1 : 30 + lat2, 75);
        check("pause_resp", int'(resp_d), int'(model(16'hACE1, 8'hC3)));

        // Reset abort after 30 evaluation stages, then a clean rerun.
        start_run(8'h96);
        repeat (31) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", int'(rdy_d), 0);
        check("abort_resp", int'(resp_d), 0);
        rst = 1'b0;
        wait_ready(100, lat);
        check("abort_rerun_lat", lat, 65);
        check("abort_rerun_resp", int'(resp_d), int'(model(16'hACE1, 8'h96)));

        // Hold in DONE, then a new challenge restarts evaluation.
        repeat (3) begin @(posedge clk); #1; end
        check("done_hold_ready", int'(rdy_d), 1);
        check("done_hold_resp", int'(resp_d), int'(model(16'hACE1, 8'h96)));
        chall_in = 8'h3C;
        @(posedge clk); #1;
        check("recap_ready_low", int'(rdy_d), 0);
        check("recap_resp_clear", int'(resp_d), 0);
        wait_ready(100, lat);
        check("recap_lat", (lat < 0) ? -1 : lat + 1, 65);
        check("recap_resp", int'(resp_d), int'(model(16'hACE1, 8'h3C)));
        check("recap_resp_1234", int'(resp_a), int'(model(16'h1234, 8'h3C)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
